// File: rtl/tx_word_serializer.sv
// tx_word_serializer: splits each accepted readout word into bytes for the UART,
// lowest enabled group first. At most one byte is emitted every two cycles.
module tx_word_serializer #(
    parameter int GROUPS = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [8*GROUPS-1:0] word_i,
    input  logic                stb_i,
    output logic                rdy_o,
    input  logic [GROUPS-1:0]   grp_en_i,
    output logic [7:0]          byte_o,
    output logic                byte_stb_o,
    input  logic                uart_rdy_i,
    output logic                busy_o,
    output logic                ovf_o
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t              state;
    logic [8*GROUPS-1:0] wreg;
    logic [GROUPS-1:0]   pending;
    logic [GROUPS-1:0]   pending_clr;
    logic [7:0]          next_byte;

    // Byte of the lowest pending group; pending_clr drops that group's bit.
    always_comb begin
        next_byte = '0;
        for (int g = GROUPS - 1; g >= 0; g--) begin
            if (pending[g]) next_byte = wreg[8*g +: 8];
        end
        pending_clr = pending & (pending - GROUPS'(1));
    end

    always_ff @(posedge clk_i) begin
        if (state == IDLE && stb_i) wreg <= word_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            pending    <= '0;
            rdy_o      <= 1'b1;
            busy_o     <= 1'b0;
            byte_stb_o <= 1'b0;
            byte_o     <= 8'h00;
            ovf_o      <= 1'b0;
        end else begin
            if (stb_i && !rdy_o) ovf_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (stb_i) begin
                        pending <= grp_en_i;
                        rdy_o   <= 1'b0;
                        busy_o  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (pending == '0) begin
                        rdy_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else if (uart_rdy_i) begin
                        byte_o     <= next_byte;
                        byte_stb_o <= 1'b1;
                        pending    <= pending_clr;
                        state      <= GAP;
                    end
                end
                // The UART ready flag lags our strobe by a cycle, so it is not trusted here.
                GAP: begin
                    byte_stb_o <= 1'b0;
                    if (pending == '0) begin
                        rdy_o  <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state <= SEND;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_word_serializer.sv
// Bench for tx_word_serializer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a byte-queue timing model.
module tb_tx_word_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] word;
    logic        stb;
    logic [3:0]  grp_en;
    logic        uart_rdy;
    logic        rdy;
    logic [7:0]  byte_q;
    logic        byte_stb;
    logic        busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    tx_word_serializer #(.GROUPS(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .word_i     (word),
        .stb_i      (stb),
        .rdy_o      (rdy),
        .grp_en_i   (grp_en),
        .byte_o     (byte_q),
        .byte_stb_o (byte_stb),
        .uart_rdy_i (uart_rdy),
        .busy_o     (busy),
        .ovf_o      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a word becomes a queue of bytes of its enabled groups. A byte may leave
    // at an edge no earlier than next_ok while the UART is ready; bytes are spaced by
    // two edges, and ready returns one edge after the last byte (or after accept).
    int         cyc = 0;
    logic       m_rdy, m_stb, m_ovf;
    logic [7:0] m_byte;
    logic [7:0] q[$];
    int         next_ok;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_rdy = 1; m_stb = 0; m_byte = 8'h00; m_ovf = 0;
            q.delete();
        end else begin
            m_stb = 0;
            if (stb && !m_rdy) m_ovf = 1;
            if (m_rdy) begin
                if (stb) begin
                    q.delete();
                    for (int g = 0; g < 4; g++)
                        if (grp_en[g]) q.push_back(word[8*g +: 8]);
                    m_rdy = 0;
                    next_ok = cyc + 1;
                end
            end else if (cyc >= next_ok) begin
                if (q.size() == 0) begin
                    m_rdy = 1;
                end else if (uart_rdy) begin
                    m_byte = q.pop_front();
                    m_stb = 1;
                    next_ok = (q.size() == 0) ? cyc + 1 : cyc + 2;
                end
            end
        end
    end

    // Per-cycle compare plus a log of strobes and ready rises for directed checks.
    logic [7:0] log_b[$];
    int         log_c[$];
    int         rise_cyc = 0;
    logic       prev_rdy = 1'b1;
    logic       prev_stb = 1'b0;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("rdy", rdy, m_rdy);
            check("busy", busy, !m_rdy);
            check("byte_stb", byte_stb, m_stb);
            check("byte", byte_q, m_byte);
            check("ovf", ovf, m_ovf);
            if (byte_stb) begin
                check("stb_back_to_back", prev_stb, 1'b0);
                log_b.push_back(byte_q);
                log_c.push_back(cyc);
            end
            if (rdy && !prev_rdy) rise_cyc = cyc;
            prev_rdy = rdy;
            prev_stb = byte_stb;
        end
    end

    task automatic wait_rdy();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rdy) return;
        end
        check("rdy_timeout", 0, 1);
    endtask

    // Returns with cyc equal to the accept edge.
    task automatic send_word(input logic [31:0] w, input logic [3:0] en, output int k);
        if (!rdy) wait_rdy();
        word = w; grp_en = en; stb = 1'b1;
        @(negedge clk);
        k = cyc;
        stb = 1'b0;
        grp_en = ~en;
    endtask

    task automatic check_burst(input string name, input int k, input logic [31:0] exp_b,
                               input int n, input int first_off, input int rise_off);
        check({name, "_count"}, log_b.size(), n);
        for (int i = 0; i < n && i < log_b.size(); i++) begin
            check({name, "_byte"}, log_b[i], exp_b[8*i +: 8]);
            check({name, "_offset"}, log_c[i] - k, first_off + 2*i);
        end
        check({name, "_rdy_rise"}, rise_cyc - k, rise_off);
    endtask

    task automatic clear_log();
        log_b.delete();
        log_c.delete();
    endtask

    initial begin
        int k;
        rst = 1'b1; word = '0; stb = 1'b0; grp_en = 4'hF; uart_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rdy", rdy, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_stb", byte_stb, 1'b0);
        check("reset_byte", byte_q, 8'h00);
        check("reset_ovf", ovf, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: full word, UART always ready
        clear_log();
        send_word(32'hDDCCBBAA, 4'hF, k);
        wait_rdy(); repeat (2) @(negedge clk);
        check_burst("t1", k, 32'hDDCCBBAA, 4, 1, 8);

        // 2: groups 1 and 3 only
        clear_log();
        send_word(32'h44332211, 4'b1010, k);
        wait_rdy(); repeat (2) @(negedge clk);
        check_burst("t2", k, 32'h00004422, 2, 1, 4);

        // 3: UART busy for 5 cycles after accept
        clear_log();
        uart_rdy = 1'b0;
        send_word(32'h87654321, 4'hF, k);
        repeat (5) @(negedge clk);
        check("t3_no_early_byte", log_b.size(), 0);
        uart_rdy = 1'b1;
        wait_rdy(); repeat (2) @(negedge clk);
        check_burst("t3", k, 32'h87654321, 4, 6, 13);

        // 4: no groups enabled
        clear_log();
        send_word(32'h12345678, 4'h0, k);
        repeat (3) @(negedge clk);
        check("t4_count", log_b.size(), 0);
        check("t4_rdy_rise", rise_cyc - k, 1);
        check("t4_ovf", ovf, 1'b0);

        // 5: second word while busy is dropped and flags overflow
        clear_log();
        send_word(32'h0D0C0B0A, 4'hF, k);
        @(negedge clk);
        word = 32'hEEEEEEEE; grp_en = 4'hF; stb = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        check("t5_ovf_set", ovf, 1'b1);
        wait_rdy(); repeat (4) @(negedge clk);
        check_burst("t5", k, 32'h0D0C0B0A, 4, 1, 8);
        check("t5_ovf_sticky", ovf, 1'b1);

        // 6: reset after the second byte aborts the word
        clear_log();
        send_word(32'h11223344, 4'hF, k);
        for (int i = 0; i < 50 && log_b.size() < 2; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_stb_after_rst", byte_stb, 1'b0);
        check("t6_rdy_after_rst", rdy, 1'b1);
        check("t6_ovf_after_rst", ovf, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_more_bytes", log_b.size(), 2);
        clear_log();
        send_word(32'hCAFEF00D, 4'hF, k);
        wait_rdy(); repeat (2) @(negedge clk);
        check_burst("t6_next", k, 32'hCAFEF00D, 4, 1, 8);

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            stb      = ($urandom_range(0, 3) == 0);
            word     = $urandom;
            grp_en   = 4'($urandom_range(0, 15));
            uart_rdy = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end
        rst = 1'b0; stb = 1'b0; uart_rdy = 1'b1;
        repeat (30) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
